// File: rtl/mpwm_pkg.sv
// Shared definitions for the mpwm register block: address map, AXI response codes,
// FSM state encodings and small decode/merge helpers.
package mpwm_pkg;

   localparam logic [31:0] MPWM_ID_VALUE = 32'h4D50_0100;
   localparam int unsigned MPWM_NUM_CFG  = 4;

   localparam logic [31:0] OFF_REG0   = 32'h00;
   localparam logic [31:0] OFF_REG1   = 32'h04;
   localparam logic [31:0] OFF_REG2   = 32'h08;
   localparam logic [31:0] OFF_REG3   = 32'h0C;
   localparam logic [31:0] OFF_ID     = 32'h10;
   localparam logic [31:0] OFF_STATUS = 32'h14;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [0:0] W_IDLE = 1'b0;
   localparam logic [0:0] W_RESP = 1'b1;
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   typedef struct packed {
      logic       is_cfg;
      logic       is_id;
      logic       is_status;
      logic [1:0] cfg_ix;
   } addr_dec_t;

   // Byte address in, word-level classification out; addr[1:0] never matters.
   function automatic addr_dec_t decode_addr(input logic [31:0] byte_addr);
      addr_dec_t   dec;
      logic [31:0] off;
      off           = byte_addr & ~32'h3;
      dec.is_cfg    = (off <= OFF_REG3);
      dec.is_id     = (off == OFF_ID);
      dec.is_status = (off == OFF_STATUS);
      dec.cfg_ix    = off[3:2];
      return dec;
   endfunction

   function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mpwm_axil_regs.sv
// AXI4-Lite slave holding the four mpwm channel configuration words plus ID/STATUS.
//
//   state  | meaning
//   W_IDLE | accepting AW and W independently; commits once both are present
//   W_RESP | write response held on B until BREADY
//   R_IDLE | ARREADY high, waiting for a read address
//   R_DATA | read data held on R until RREADY
module mpwm_axil_regs
   import mpwm_pkg::*;
#(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 5,
   parameter logic [31:0] C_ID_VALUE         = MPWM_ID_VALUE
) (
   input  logic                              ACLK,
   input  logic                              ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [32*MPWM_NUM_CFG-1:0]        pwm_cfg,
   output logic [MPWM_NUM_CFG-1:0]           pwm_cfg_upd
);

   logic                              ready_en;
   logic [0:0]                        w_state;
   logic [0:0]                        r_state;
   logic                              aw_held;
   logic                              w_held;
   logic [C_S_AXI_ADDR_WIDTH-1:0]     aw_addr_q;
   logic [31:0]                       w_data_q;
   logic [3:0]                        w_strb_q;
   logic [MPWM_NUM_CFG-1:0][31:0]     cfg_q;
   logic [15:0]                       write_count;
   logic                              bvalid_q;
   logic [1:0]                        bresp_q;
   logic                              rvalid_q;
   logic [1:0]                        rresp_q;
   logic [31:0]                       rdata_q;
   logic [MPWM_NUM_CFG-1:0]           upd_q;

   logic                              aw_hs;
   logic                              w_hs;
   logic                              ar_hs;
   logic                              b_hs;
   logic                              r_hs;
   logic                              commit;
   logic [C_S_AXI_ADDR_WIDTH-1:0]     wr_addr;
   logic [31:0]                       wr_data;
   logic [3:0]                        wr_strb;
   addr_dec_t                         wr_dec;
   addr_dec_t                         rd_dec;
   logic [31:0]                       rd_word;
   logic [1:0]                        rd_resp;
   logic                              unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_dec.is_id, wr_dec.is_status};

   // ready_en keeps every READY low until the first clock edge after reset release.
   assign S_AXI_AWREADY = ready_en && (w_state == W_IDLE) && !aw_held;
   assign S_AXI_WREADY  = ready_en && (w_state == W_IDLE) && !w_held;
   assign S_AXI_ARREADY = ready_en && (r_state == R_IDLE);

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
   assign b_hs  = bvalid_q && S_AXI_BREADY;
   assign r_hs  = rvalid_q && S_AXI_RREADY;

   // A payload handshaking this cycle is used directly, so AW+W together commit at once
   // and back-to-back writes need only two cycles each.
   assign wr_addr = aw_held ? aw_addr_q : S_AXI_AWADDR;
   assign wr_data = w_held  ? w_data_q  : S_AXI_WDATA;
   assign wr_strb = w_held  ? w_strb_q  : S_AXI_WSTRB;
   assign commit  = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

   assign wr_dec = decode_addr(32'(wr_addr));
   assign rd_dec = decode_addr(32'(S_AXI_ARADDR));

   always_comb begin
      rd_word = '0;
      rd_resp = RESP_OKAY;
      if (rd_dec.is_cfg) begin
         rd_word = cfg_q[rd_dec.cfg_ix];
      end else if (rd_dec.is_id) begin
         rd_word = C_ID_VALUE;
      end else if (rd_dec.is_status) begin
         rd_word = {16'h0000, write_count};
      end else begin
         rd_resp = RESP_SLVERR;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         ready_en <= 1'b0;
      end else begin
         ready_en <= 1'b1;
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         w_state   <= W_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_hs) begin
                  aw_held   <= 1'b1;
                  aw_addr_q <= S_AXI_AWADDR;
               end
               if (w_hs) begin
                  w_held   <= 1'b1;
                  w_data_q <= S_AXI_WDATA;
                  w_strb_q <= S_AXI_WSTRB;
               end
               if (commit) begin
                  w_state  <= W_RESP;
                  bvalid_q <= 1'b1;
                  bresp_q  <= wr_dec.is_cfg ? RESP_OKAY : RESP_SLVERR;
               end
            end
            W_RESP: begin
               if (b_hs) begin
                  w_state  <= W_IDLE;
                  bvalid_q <= 1'b0;
                  aw_held  <= 1'b0;
                  w_held   <= 1'b0;
               end
            end
            default: w_state <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         cfg_q       <= '0;
         write_count <= '0;
         upd_q       <= '0;
      end else begin
         upd_q <= '0;
         if (commit && wr_dec.is_cfg) begin
            cfg_q[wr_dec.cfg_ix] <= merge_strb(cfg_q[wr_dec.cfg_ix], wr_data, wr_strb);
            write_count          <= write_count + 16'd1;
            upd_q[wr_dec.cfg_ix] <= 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state  <= R_IDLE;
         rvalid_q <= 1'b0;
         rresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  r_state  <= R_DATA;
                  rvalid_q <= 1'b1;
                  rdata_q  <= rd_word;
                  rresp_q  <= rd_resp;
               end
            end
            R_DATA: begin
               if (r_hs) begin
                  r_state  <= R_IDLE;
                  rvalid_q <= 1'b0;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   assign S_AXI_BVALID = bvalid_q;
   assign S_AXI_BRESP  = bresp_q;
   assign S_AXI_RVALID = rvalid_q;
   assign S_AXI_RRESP  = rresp_q;
   assign S_AXI_RDATA  = rdata_q;
   assign pwm_cfg      = cfg_q;
   assign pwm_cfg_upd  = upd_q;

endmodule
